// File: rtl/buffer_if_id_hazard_pkg.sv
// Shared MIPS pipeline definitions: opcodes, NOP encoding and IF/ID control states.
package mips_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } ifid_state_t;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/buffer_if_id_hazard_if.sv
// Fetch-side and decode-side signal bundle of the IF/ID buffer.
interface buffer_if_id_hazard_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      i_instruction;
    logic [31:0]      i_address_pc;
    logic [1:0]       i_idex_memRead;
    logic [4:0]       i_idex_rt;
    logic             i_pcsrc;

    logic [31:0]      o_instruction;
    logic [31:0]      o_address_pc;
    logic             o_valid;
    logic             o_pc_write;
    logic             o_bubble;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_instruction, i_address_pc, i_idex_memRead, i_idex_rt, i_pcsrc,
        input  o_instruction, o_address_pc, o_valid, o_pc_write, o_bubble,
               o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_instruction, i_address_pc, i_idex_memRead, i_idex_rt, i_pcsrc,
        output o_instruction, o_address_pc, o_valid, o_pc_write, o_bubble,
               o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/buffer_if_id_hazard_hazard_detect_unit.sv
// Combinational load-use comparator between the IF/ID instruction and a load in ID/EX.
module hazard_detect_unit
    import mips_pipe_pkg::*;
(
    input  logic [31:0] i_instruction,
    input  logic [1:0]  i_idex_memRead,
    input  logic [4:0]  i_idex_rt,
    input  logic        i_valid,
    input  logic        i_enable,
    output logic        o_hazard
);
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_lo;

    assign opcode    = i_instruction[31:26];
    assign rs        = i_instruction[25:21];
    assign rt        = i_instruction[20:16];
    assign unused_lo = ^i_instruction[15:0];

    // Writes to $0 are discarded, so a load targeting $0 never creates a dependency.
    assign o_hazard = i_enable && i_valid && (i_idex_memRead != '0) && (i_idex_rt != '0) &&
                      ((i_idex_rt == rs) || ((i_idex_rt == rt) && reads_rt(opcode)));
endmodule

// File: rtl/buffer_if_id_hazard.sv
// IF/ID pipeline register with load-use stall, branch/jump flush and debug event counters.
module buffer_if_id_hazard
    import mips_pipe_pkg::*;
#(
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    buffer_if_id_hazard_if.slave  bus
);
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

    ifid_state_t      state, state_next;
    logic [1:0]       remaining, remaining_next;
    logic [31:0]      instr_q;
    logic [31:0]      pc_q;
    logic             valid_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic hazard;
    logic pc_write;
    logic bubble;
    logic force_nop;
    logic stall_evt;
    logic flush_evt;

    hazard_detect_unit u_hazard (
        .i_instruction  (instr_q),
        .i_idex_memRead (bus.i_idex_memRead),
        .i_idex_rt      (bus.i_idex_rt),
        .i_valid        (valid_q),
        .i_enable       (state == RUN),
        .o_hazard       (hazard)
    );

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        pc_write       = 1'b1;
        bubble         = 1'b0;
        force_nop      = 1'b0;
        stall_evt      = 1'b0;
        flush_evt      = 1'b0;
        if (bus.i_pcsrc) begin
            force_nop = 1'b1;
            bubble    = 1'b1;
            flush_evt = 1'b1;
            if (FLUSH_DEPTH == 1) begin
                state_next = RUN;
            end else begin
                state_next     = FLUSH;
                remaining_next = FLUSH_RELOAD;
            end
        end else if (hazard) begin
            pc_write   = 1'b0;
            bubble     = 1'b1;
            stall_evt  = 1'b1;
            state_next = STALL;
        end else begin
            case (state)
                STALL: state_next = RUN;
                FLUSH: begin
                    force_nop      = 1'b1;
                    remaining_next = remaining - 2'd1;
                    if (remaining == 2'd1) state_next = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            remaining <= '0;
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            if (!stall_evt) begin
                instr_q <= force_nop ? NOP_INSTR : bus.i_instruction;
                pc_q    <= bus.i_address_pc;
                valid_q <= !force_nop;
            end
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Reset dominates the combinational controls too, so fetch never sees a stray bubble.
    assign bus.o_pc_write    = pc_write | rst;
    assign bus.o_bubble      = bubble & ~rst;
    assign bus.o_instruction = instr_q;
    assign bus.o_address_pc  = pc_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_stall_cnt   = stall_cnt;
    assign bus.o_flush_cnt   = flush_cnt;
endmodule
